// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: core (M0) has priority,
// loader (M1) is protected by a starvation counter and can lock bursts.
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {
    OWNER_M0,
    OWNER_M1
  } ownerT;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  logic       arbEn;
  logic       locked;
  logic [3:0] starveCnt;
  ownerT      owner;
  logic       m1Wins;

  always_comb begin
    m1Wins = locked || (starveCnt == StarveMax) || !m0_req;
    m1_gnt = arbEn && m1_req && m1Wins;
    m0_gnt = arbEn && m0_req && !m1_gnt;
  end

  // Idle cycles present M0's address/data so the memory sees a stable default.
  always_comb begin
    mem_addr  = m1_gnt ? m1_addr  : m0_addr;
    mem_wdata = m1_gnt ? m1_wdata : m0_wdata;
    mem_we    = (m0_gnt && m0_we) || (m1_gnt && m1_we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arbEn     <= 1'b0;
      owner     <= OWNER_M0;
      locked    <= 1'b0;
      starveCnt <= '0;
      m0_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      arbEn     <= 1'b1;
      locked    <= m1_gnt && m1_lock;
      m0_rvalid <= m0_gnt && !m0_we;
      m1_rvalid <= m1_gnt && !m1_we;

      if (m0_gnt && !m0_we) m0_rdata <= mem_rdata;
      if (m1_gnt && !m1_we) m1_rdata <= mem_rdata;

      if (m0_gnt)      owner <= OWNER_M0;
      else if (m1_gnt) owner <= OWNER_M1;

      if (m1_gnt || !m1_req)                     starveCnt <= '0;
      else if (m0_gnt && starveCnt != StarveMax) starveCnt <= starveCnt + 4'd1;
    end
  end

  // owner is debug-only state; this keeps it tied to the grant history.
  ownerAfterGrant: assert property (@(posedge clk) disable iff (!rst_n)
    (m1_gnt |=> owner == OWNER_M1) and (m0_gnt |=> owner == OWNER_M0));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic, both
// checked against a cycle-level reference of the arbitration rules and memory.
module tb_dmem_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0Req, m0We, m1Req, m1We, m1Lock;
  logic [31:0] m0Addr, m0Wdata, m1Addr, m1Wdata;
  logic        m0Gnt, m0Rvalid, m1Gnt, m1Rvalid, memWe;
  logic [31:0] m0Rdata, m1Rdata, memAddr, memWdata, memRdata;

  logic [31:0] mem    [0:63] = '{default: '0};
  logic [31:0] refMem [0:63] = '{default: '0};

  int tests = 0;
  int fails = 0;

  // Reference state: what the arbiter should look like after the last edge.
  logic        arbOn, mLocked, mRv0, mRv1;
  logic [31:0] mRd0, mRd1;
  int          mWait;

  logic        obsG0, obsG1, obsRv0, obsRv1;
  logic [31:0] obsRd0, obsRd1;
  logic        expG0, expG1;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(STARVE)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0Req), .m0_we(m0We), .m0_addr(m0Addr), .m0_wdata(m0Wdata),
    .m0_gnt(m0Gnt), .m0_rvalid(m0Rvalid), .m0_rdata(m0Rdata),
    .m1_req(m1Req), .m1_we(m1We), .m1_lock(m1Lock), .m1_addr(m1Addr),
    .m1_wdata(m1Wdata), .m1_gnt(m1Gnt), .m1_rvalid(m1Rvalid), .m1_rdata(m1Rdata),
    .mem_we(memWe), .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata)
  );

  always #5 clk = ~clk;

  assign memRdata = mem[memAddr[7:2]];
  always @(posedge clk) if (memWe) mem[memAddr[7:2]] <= memWdata;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    arbOn = 1'b0; mLocked = 1'b0; mWait = 0;
    mRv0 = 1'b0; mRv1 = 1'b0; mRd0 = '0; mRd1 = '0;
  endtask

  // One clock cycle: inputs are already driven; check mid-cycle, then advance.
  task automatic step();
    @(negedge clk);
    #1;
    expG1 = arbOn && m1Req && (mLocked || mWait == STARVE || !m0Req);
    expG0 = arbOn && m0Req && !expG1;
    obsG0 = m0Gnt; obsG1 = m1Gnt;
    obsRv0 = m0Rvalid; obsRv1 = m1Rvalid; obsRd0 = m0Rdata; obsRd1 = m1Rdata;
    checkVal("m0_gnt", 32'(m0Gnt), 32'(expG0));
    checkVal("m1_gnt", 32'(m1Gnt), 32'(expG1));
    checkVal("mem_we", 32'(memWe), 32'((expG0 && m0We) || (expG1 && m1We)));
    checkVal("mem_addr", memAddr, expG1 ? m1Addr : m0Addr);
    checkVal("mem_wdata", memWdata, expG1 ? m1Wdata : m0Wdata);
    checkVal("m0_rvalid", 32'(m0Rvalid), 32'(mRv0));
    checkVal("m1_rvalid", 32'(m1Rvalid), 32'(mRv1));
    checkVal("m0_rdata", m0Rdata, mRd0);
    checkVal("m1_rdata", m1Rdata, mRd1);
    if (rst_n) begin
      mRv0 = expG0 && !m0We;
      mRv1 = expG1 && !m1We;
      if (mRv0) mRd0 = refMem[m0Addr[7:2]];
      if (mRv1) mRd1 = refMem[m1Addr[7:2]];
      if (expG0 && m0We) refMem[m0Addr[7:2]] = m0Wdata;
      if (expG1 && m1We) refMem[m1Addr[7:2]] = m1Wdata;
      if (expG1 || !m1Req)              mWait = 0;
      else if (expG0 && mWait < STARVE) mWait++;
      mLocked = expG1 && m1Lock;
      arbOn = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [9:0] pattern;
    bit         started;

    modelReset();
    rst_n = 1'b0;
    m0Req = 1'b1; m0We = 1'b1; m0Addr = 32'h40; m0Wdata = 32'h0BAD_F00D;
    m1Req = 1'b0; m1We = 1'b0; m1Lock = 1'b0; m1Addr = '0; m1Wdata = '0;
    step();
    step();

    // Reset release with a held M0 write.
    rst_n = 1'b1;
    step();
    checkVal("rel_first_gnt", 32'(obsG0), 32'd0);
    step();
    checkVal("rel_second_gnt", 32'(obsG0), 32'd1);

    // M0 read of 0x10 holding 0xDEADBEEF.
    m0We = 1'b1; m0Addr = 32'h10; m0Wdata = 32'hDEAD_BEEF;
    step();
    m0We = 1'b0;
    step();
    checkVal("rd_gnt", 32'(obsG0), 32'd1);
    m0Req = 1'b0;
    step();
    checkVal("rd_rvalid_t1", 32'(obsRv0), 32'd1);
    checkVal("rd_rdata_t1", obsRd0, 32'hDEAD_BEEF);
    step();
    checkVal("rd_rvalid_t2", 32'(obsRv0), 32'd0);

    // M1 locked burst of three writes against a continuous M0 request.
    m0Req = 1'b1; m0We = 1'b0; m0Addr = 32'h0;
    m1Req = 1'b1; m1We = 1'b1; m1Lock = 1'b1; m1Addr = 32'h80; m1Wdata = 32'hA1;
    started = 1'b0;
    for (int i = 0; i < 10 && !started; i++) begin
      step();
      started = obsG1;
    end
    checkVal("burst_start", 32'(started), 32'd1);
    m1Addr = 32'h84; m1Wdata = 32'hA2;
    step();
    checkVal("burst_beat2", 32'(obsG1), 32'd1);
    m1Addr = 32'h88; m1Wdata = 32'hA3; m1Lock = 1'b0;
    step();
    checkVal("burst_beat3", 32'(obsG1), 32'd1);
    m1Req = 1'b0;
    step();
    checkVal("burst_then_m0", 32'(obsG0), 32'd1);
    checkVal("burst_mem0", mem[32], 32'hA1);
    checkVal("burst_mem1", mem[33], 32'hA2);
    checkVal("burst_mem2", mem[34], 32'hA3);

    // Both requesting continuously: M1 gets every fifth cycle.
    m1Req = 1'b1; m1We = 1'b0; m1Addr = 32'h84;
    for (int i = 0; i < 10; i++) begin
      step();
      pattern[i] = obsG1;
    end
    checkVal("starve_pattern", 32'(pattern), 32'b10_0001_0000);

    // Async reset right after an M1 read grant.
    m0Req = 1'b0; m1Addr = 32'h80;
    step();
    checkVal("rst_m1_gnt", 32'(obsG1), 32'd1);
    rst_n = 1'b0;
    modelReset();
    m1Req = 1'b0;
    #1;
    checkVal("rst_m1_rvalid", 32'(m1Rvalid), 32'd0);
    checkVal("rst_m1_rdata", m1Rdata, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    checkVal("post_rst_gnt", 32'(obsG1 | obsG0), 32'd0);
    checkVal("post_rst_rvalid", 32'(obsRv1), 32'd0);

    // M0 write then M1 read of the same word.
    m0Req = 1'b1; m0We = 1'b1; m0Addr = 32'h20; m0Wdata = 32'h1234_5678;
    step();
    m0Req = 1'b0; m1Req = 1'b1; m1We = 1'b0; m1Addr = 32'h20;
    step();
    m1Req = 1'b0;
    step();
    checkVal("wr_rd_rvalid", 32'(obsRv1), 32'd1);
    checkVal("wr_rd_rdata", obsRd1, 32'h1234_5678);

    // Randomized traffic obeying the hold-until-granted protocol.
    for (int n = 0; n < 600; n++) begin
      if (!m0Req || expG0) begin
        m0Req = ($urandom_range(0, 3) != 0);
        m0We = $urandom_range(0, 1) == 1;
        m0Addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        m0Wdata = $urandom;
      end
      if (!m1Req || expG1) begin
        m1Req = ($urandom_range(0, 2) != 0);
        m1We = $urandom_range(0, 1) == 1;
        m1Lock = $urandom_range(0, 1) == 1;
        m1Addr = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
        m1Wdata = $urandom;
      end
      if (n == 300) begin
        rst_n = 1'b0;
        modelReset();
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
